// File: rtl/tile_freq_meter.sv
// rtl/tile_freq_meter.sv - gated rising-edge counter for one selectable tile signal
//
// Purpose: counts rising edges of a selected, synchronised tile signal over a
// fixed window of GATE_CYCLES clk cycles, then latches the result. Supports
// single-shot and continuous operation, and saturates with overflow reporting.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   tile_sig   asynchronous tile signals (each slower than clk/2)
//   sel        tile index, captured on start and at continuous restarts
//   start      level-sampled run request, honoured only when idle
//   continuous 1 = restart automatically after each report
//   byte_idx   result byte selector for byte_out
//   busy       high whenever a run is in progress
//   done       one-cycle pulse while a fresh result is presented
//   overflow   result saturated
//   count      last latched result
//   byte_out   selected byte of count, 0 when byte_idx is out of range
module tile_freq_meter #(
  parameter int NUM_TILES   = 4,
  parameter int SEL_W       = $clog2(NUM_TILES),
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 1024,
  parameter int SYNC_STAGES = 2,
  localparam int BI_W       = (CNT_W > 8) ? $clog2(CNT_W / 8) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_TILES-1:0] tile_sig,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [BI_W-1:0]      byte_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_W-1:0]     count,
  output logic [7:0]           byte_out
);

  localparam int NBYTES = CNT_W / 8;
  localparam int TW     = $clog2(GATE_CYCLES + SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_GATE   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]             state;
  logic [SEL_W-1:0]       sel_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [TW-1:0]          timer;
  logic [CNT_W-1:0]       counter;
  logic [CNT_W-1:0]       cnt_next;
  logic                   ovf;
  logic                   ovf_next;
  logic                   rise;

  // Edge detector always follows the synchroniser output, so the value seen
  // on the last SETTLE cycle is the reference for the first GATE cycle.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    cnt_next = counter;
    ovf_next = ovf;
    if (state == S_GATE && rise) begin
      if (counter == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = counter + 1'b1;
      end
    end
  end

  // The mux uses the captured index so a live sel change cannot corrupt a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tile_sig[sel_q]};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sel_q    <= '0;
      timer    <= '0;
      counter  <= '0;
      ovf      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel_q <= sel;
            timer <= '0;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          counter <= '0;
          ovf     <= 1'b0;
          if (timer == TW'(SYNC_STAGES)) begin
            timer <= '0;
            state <= S_GATE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GATE: begin
          counter <= cnt_next;
          ovf     <= ovf_next;
          if (timer == TW'(GATE_CYCLES - 1)) begin
            // Latch including any edge seen on this final gate cycle.
            count    <= cnt_next;
            overflow <= ovf_next;
            timer    <= '0;
            state    <= S_REPORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_REPORT: begin
          counter <= '0;
          ovf     <= 1'b0;
          timer   <= '0;
          if (!continuous) begin
            state <= S_IDLE;
          end else if (sel == sel_q) begin
            // Same source: synchroniser is already primed, no settle gap.
            state <= S_GATE;
          end else begin
            sel_q <= sel;
            state <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_REPORT);

  always_comb begin
    byte_out = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_idx == BI_W'(i)) begin
        byte_out = count[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tile_freq_meter.sv
// tb/tb_tile_freq_meter.sv - directed self-checking bench for tile_freq_meter
module tb_tile_freq_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cyc_bits = 4'd0;
  logic       t0_hold = 1'b0;
  logic [3:0] tile_sig;

  // tile 1/2/3 periods 4/8/16 clk; tile 0 period 2 clk or held high
  assign tile_sig = {cyc_bits[3], cyc_bits[2], cyc_bits[1], t0_hold ? 1'b1 : cyc_bits[0]};

  always #5 clk = ~clk;
  always @(negedge clk) cyc_bits = cyc_bits + 4'd1;

  // A: CNT_W=16, GATE=64
  logic [1:0]  sel_a = 2'd0;
  logic        start_a = 1'b0, continuous_a = 1'b0, byte_idx_a = 1'b0;
  logic        busy_a, done_a, overflow_a;
  logic [15:0] count_a;
  logic [7:0]  byte_out_a;
  // B: CNT_W=8, GATE=1024
  logic [1:0]  sel_b = 2'd0;
  logic        start_b = 1'b0, continuous_b = 1'b0, byte_idx_b = 1'b0;
  logic        busy_b, done_b, overflow_b;
  logic [7:0]  count_b;
  logic [7:0]  byte_out_b;
  // C: CNT_W=16, GATE=9320
  logic [1:0]  sel_c = 2'd0;
  logic        start_c = 1'b0, continuous_c = 1'b0, byte_idx_c = 1'b0;
  logic        busy_c, done_c, overflow_c;
  logic [15:0] count_c;
  logic [7:0]  byte_out_c;

  tile_freq_meter #(.NUM_TILES(4), .CNT_W(16), .GATE_CYCLES(64), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .tile_sig(tile_sig), .sel(sel_a), .start(start_a),
    .continuous(continuous_a), .byte_idx(byte_idx_a), .busy(busy_a), .done(done_a),
    .overflow(overflow_a), .count(count_a), .byte_out(byte_out_a));

  tile_freq_meter #(.NUM_TILES(4), .CNT_W(8), .GATE_CYCLES(1024), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .tile_sig(tile_sig), .sel(sel_b), .start(start_b),
    .continuous(continuous_b), .byte_idx(byte_idx_b), .busy(busy_b), .done(done_b),
    .overflow(overflow_b), .count(count_b), .byte_out(byte_out_b));

  tile_freq_meter #(.NUM_TILES(4), .CNT_W(16), .GATE_CYCLES(9320), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .rst(rst), .tile_sig(tile_sig), .sel(sel_c), .start(start_c),
    .continuous(continuous_c), .byte_idx(byte_idx_c), .busy(busy_c), .done(done_c),
    .overflow(overflow_c), .count(count_c), .byte_out(byte_out_c));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Counts negedges until the chosen instance shows done; starts are dropped
  // after the first edge so each call issues at most a one-cycle request.
  task automatic wait_done(input int which, input int lim, output int n);
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < lim) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
      n++;
      case (which)
        0:       d = done_a;
        1:       d = done_b;
        default: d = done_c;
      endcase
    end
  endtask

  int n, done_at, npulse, nbusy;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_count", count_a, 0);
    check("rst_ovf_b", overflow_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // single shot on tile 2 with ignored start pulse and sel change mid-gate
    sel_a = 2'd2;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    done_at = 0; npulse = 0; nbusy = 0;
    for (int i = 1; i <= 80; i++) begin
      if (done_a) begin
        npulse++;
        if (done_at == 0) done_at = i;
      end
      if (busy_a) nbusy++;
      if (i == 20) start_a = 1'b1;
      if (i == 21) start_a = 1'b0;
      if (i == 30) sel_a = 2'd1;
      @(negedge clk);
    end
    check("single_done_cycle", done_at, 68);
    check("single_done_pulses", npulse, 1);
    check("single_busy_cycles", nbusy, 68);
    check("single_count", count_a, 8);
    check("single_ovf", overflow_a, 0);
    byte_idx_a = 1'b0; #1;
    check("single_byte0", byte_out_a, 8'h08);
    byte_idx_a = 1'b1; #1;
    check("single_byte1", byte_out_a, 8'h00);
    byte_idx_a = 1'b0;

    // continuous with reselect
    @(negedge clk);
    sel_a = 2'd1;
    continuous_a = 1'b1;
    start_a = 1'b1;
    wait_done(0, 200, n);
    check("cont_first_latency", n, 68);
    check("cont_first_count", count_a, 16);
    sel_a = 2'd3;
    wait_done(0, 200, n);
    check("cont_reselect_gap", n, 68);
    check("cont_reselect_count", count_a, 4);
    wait_done(0, 200, n);
    check("cont_same_gap", n, 65);
    check("cont_same_count", count_a, 4);
    @(negedge clk);
    continuous_a = 1'b0;
    wait_done(0, 200, n);
    check("cont_last_gap", n, 64);
    check("cont_last_count", count_a, 4);
    @(negedge clk);
    check("cont_idle_busy", busy_a, 0);

    // asynchronous reset mid-gate
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_rst_busy", busy_a, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_done", done_a, 0);
    check("arst_ovf", overflow_a, 0);
    check("arst_count", count_a, 0);
    check("arst_byte", byte_out_a, 0);
    @(negedge clk);
    rst = 1'b0;
    npulse = 0; nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_a) npulse++;
      if (busy_a) nbusy++;
    end
    check("arst_no_done", npulse, 0);
    check("arst_stay_idle", nbusy, 0);

    // zero activity: tile 0 held high
    t0_hold = 1'b1;
    sel_a = 2'd0;
    start_a = 1'b1;
    wait_done(0, 200, n);
    check("zero_latency", n, 68);
    check("zero_count", count_a, 0);
    check("zero_ovf", overflow_a, 0);
    t0_hold = 1'b0;

    // saturation on 8-bit instance: 512 edges
    @(negedge clk);
    sel_b = 2'd0;
    start_b = 1'b1;
    wait_done(1, 1200, n);
    check("sat_latency", n, 1028);
    check("sat_count", count_b, 8'hFF);
    check("sat_ovf", overflow_b, 1);
    byte_idx_b = 1'b0; #1;
    check("sat_byte0", byte_out_b, 8'hFF);
    byte_idx_b = 1'b1; #1;
    check("sat_byte_oob", byte_out_b, 8'h00);

    // byte readout: 4660 edges = 0x1234
    @(negedge clk);
    sel_c = 2'd0;
    start_c = 1'b1;
    wait_done(2, 9500, n);
    check("bytes_latency", n, 9324);
    check("bytes_count", count_c, 16'h1234);
    check("bytes_ovf", overflow_c, 0);
    byte_idx_c = 1'b0; #1;
    check("bytes_lo", byte_out_c, 8'h34);
    byte_idx_c = 1'b1; #1;
    check("bytes_hi", byte_out_c, 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_freq_meter.md
Name: tile_freq_meter

Overview:
- Parametrised gated edge counter for the micro-tile container.
- Measures the frequency of one selectable on-chip signal per run: ring-oscillator outputs, sensor clock or TDC strobe.
- The selected signal is synchronised and its rising edges are counted over a fixed number of `clk` cycles.
- The result is latched and exposed byte-wise on an 8-bit output port.
- Supports single-shot and continuous modes with saturation/overflow reporting.

Parameters:
- NUM_TILES, 4, number of tile signals; must be ≥2.
- SEL_W, $clog2(NUM_TILES), width of sel.
- CNT_W, 16, counter/result width; must be a multiple of 8, ≤32.
- GATE_CYCLES, 1024, gate window length in clk cycles; must be ≥1.
- SYNC_STAGES, 2, synchroniser flops on the selected signal; must be ≥2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- tile_sig, input, NUM_TILES, asynchronous tile signals; each must be slower than clk/2.
- sel, input, SEL_W, tile index. Sampled on an accepted start, and at each continuous-mode restart.
- start, input, 1, level-sampled request. Accepted only in IDLE.
- continuous, input, 1, 1 = auto-restart after each report.
- byte_idx, input, $clog2(CNT_W/8) (min 1), selects the result byte on byte_out.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a result is latched.
- overflow, output, 1, latched with the result; 1 = count saturated.
- count, output, CNT_W, last latched result.
- byte_out, output, 8, count[8*byte_idx +: 8]. Combinational from registered count; 0 for out-of-range byte_idx.

Behaviour:
- Reset (async assert, sync deassert externally):
  - state=IDLE; busy=0, done=0, overflow=0, count=0.
  - Internal counter, synchroniser, edge-detect register and gate timer all cleared.
  - Reset mid-run aborts the run with no done pulse.
- Selection path:
  - The tile mux sits in front of the synchroniser.
  - The mux index is the latched sel (sel_q), never live sel.
- FSM states: IDLE, SETTLE, GATE, REPORT.
- IDLE:
  - start=1 at edge k: sel_q<=sel, go to SETTLE at k+1.
  - start=0: stay in IDLE.
- SETTLE:
  - Lasts exactly SYNC_STAGES+1 cycles, flushing the synchroniser.
  - The edge-detect register tracks the synchronised value, so no edge is counted.
  - Internal counter is cleared.
- GATE:
  - Lasts exactly GATE_CYCLES cycles.
  - Each cycle where sync=1 and prev=0 increments the counter.
  - The counter saturates at 2^CNT_W−1 and sets the internal ovf flag. Further edges are ignored.
  - Edges on the first and last gate cycle are counted.
- REPORT (one cycle):
  - count<=counter value and overflow<=ovf at entry; done=1 this cycle only.
  - continuous=0: go to IDLE.
  - continuous=1 and sel==sel_q: go directly to GATE. Counter and ovf are cleared, edge-detect continues (no settle gap).
  - continuous=1 and sel!=sel_q: sel_q<=sel, go to SETTLE.
- start while busy: ignored. start held high in IDLE after a run starts a new run.
- continuous deasserted mid-run: the current run completes, then returns to IDLE.
- sel changes mid-run: no effect until the next restart.
- count/overflow hold their value between reports; no update outside REPORT.
- Latency: start sampled at edge k ⇒ done high in cycle k+1+(SYNC_STAGES+1)+GATE_CYCLES.
- Continuous, same sel: period between done pulses = GATE_CYCLES+1 cycles.

Test Plan:
- Reset: assert rst asynchronously mid-GATE (NUM_TILES=4, GATE_CYCLES=64) -> busy, done, overflow, count, byte_out all 0 immediately; no done pulse afterwards.
- Single shot: tile_sig[2] toggles with period 8 clk, sel=2, start one cycle at edge k, SYNC_STAGES=2, GATE_CYCLES=64 -> done only at cycle k+68; count=8; overflow=0; busy high cycles k+1..k+68.
- Saturation: CNT_W=8, GATE_CYCLES=1024, tile period 2 clk -> count=255, overflow=1; byte_idx=0 gives byte_out=0xFF.
- Continuous + reselect: continuous=1, sel=1 with period 4; after first done set sel=3 (period 16). Expect:
  - first count=16;
  - second run includes a 3-cycle SETTLE, done 68 cycles later, count=4;
  - with sel unchanged, done pulses spaced exactly 65 cycles.
- Byte readout and ignore: CNT_W=16, count result 0x1234 -> byte_idx 0/1 give 0x34/0x12. start pulses during GATE and a sel change during GATE leave the result and timing unchanged.
- Zero activity: selected tile held constant 1 through the whole run -> count=0, overflow=0; no edge counted at the SETTLE/GATE boundary.
